// File: rtl/tick_sweep_sequencer_if.sv
// Environment write-port bundle produced by tick_sweep_sequencer: cell coordinate,
// commit strobe, location-freeze request and sweep status.
interface tick_sweep_sequencer_if #(
  parameter int X_bits   = 8,
  parameter int Y_bits   = 7,
  parameter int CNT_bits = 16
);
  logic [X_bits-1:0]   writeLoc_x;
  logic [Y_bits-1:0]   writeLoc_y;
  logic                write_flag;
  logic                hold_locs;
  logic                sweep_busy;
  logic                frame_done;
  logic                tick_overrun;
  logic [CNT_bits-1:0] sweep_count;

  modport master (
    output writeLoc_x, writeLoc_y, write_flag, hold_locs,
           sweep_busy, frame_done, tick_overrun, sweep_count
  );

  modport slave (
    input  writeLoc_x, writeLoc_y, write_flag, hold_locs,
           sweep_busy, frame_done, tick_overrun, sweep_count
  );
endinterface

// File: rtl/tick_sweep_sequencer.sv
// Per-game-tick grid sweep sequencer: fetch/commit pair per cell, raster order by default,
// boustrophedon order when SWEEP_SERPENTINE_EN is defined.
module tick_sweep_sequencer #(
  parameter int X_bits   = 8,
  parameter int Y_bits   = 7,
  parameter int X_MAX    = 159,
  parameter int Y_MAX    = 119,
  parameter int CNT_bits = 16
) (
  input  logic                   newLocClock,
  input  logic                   RESET_SIM_N,
  input  logic                   RUN,
  input  logic                   game_tick,
  input  logic                   KEY_PAUSE,
  tick_sweep_sequencer_if.master wr
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    ARM    = 3'd1,
    FETCH  = 3'd2,
    COMMIT = 3'd3,
    DONE   = 3'd4
  } state_t;

  localparam logic [X_bits-1:0]   X_ZERO  = {X_bits{1'b0}};
  localparam logic [X_bits-1:0]   X_ONE   = {{(X_bits-1){1'b0}}, 1'b1};
  localparam logic [X_bits-1:0]   X_LAST  = X_MAX[X_bits-1:0];
  localparam logic [Y_bits-1:0]   Y_ZERO  = {Y_bits{1'b0}};
  localparam logic [Y_bits-1:0]   Y_ONE   = {{(Y_bits-1){1'b0}}, 1'b1};
  localparam logic [Y_bits-1:0]   Y_LAST  = Y_MAX[Y_bits-1:0];
  localparam logic [CNT_bits-1:0] CNT_ONE = {{(CNT_bits-1){1'b0}}, 1'b1};
`ifdef SWEEP_SERPENTINE_EN
  localparam logic [X_bits-1:0]   X_END   = ((Y_MAX % 2) == 1) ? X_ZERO : X_LAST;
`endif

  state_t              state_r, state_s;
  logic [X_bits-1:0]   x_r, x_s, x_next_s;
  logic [Y_bits-1:0]   y_r, y_s, y_next_s;
  logic                last_cell_s;
  logic                pause_meta_r, pause_sync_r, paused_s;
  logic                game_tick_smp_r, game_tick_q_r, tick_rise_s;
  logic                write_flag_r, hold_locs_r, busy_r, frame_done_r, overrun_r;
  logic [CNT_bits-1:0] count_r;

  assign paused_s    = ~pause_sync_r;
  // game_tick is sampled once so the rise is seen in the cycle after the sampling edge
  assign tick_rise_s = game_tick_smp_r & ~game_tick_q_r;

  // Pause synchronizer and game-tick edge detector
  always_ff @(posedge newLocClock or negedge RESET_SIM_N) begin
    if (!RESET_SIM_N) begin
      pause_meta_r    <= 1'b1;
      pause_sync_r    <= 1'b1;
      game_tick_smp_r <= 1'b0;
      game_tick_q_r   <= 1'b0;
    end else begin
      pause_meta_r    <= KEY_PAUSE;
      pause_sync_r    <= pause_meta_r;
      game_tick_smp_r <= game_tick;
      game_tick_q_r   <= game_tick_smp_r;
    end
  end

  // Successor of the current cell in scan order and end-of-sweep detection
  always_comb begin
    x_next_s    = x_r;
    y_next_s    = y_r;
    last_cell_s = 1'b0;
`ifdef SWEEP_SERPENTINE_EN
    if (y_r[0] == 1'b0) begin
      if (x_r == X_LAST) begin
        y_next_s = y_r + Y_ONE;
      end else begin
        x_next_s = x_r + X_ONE;
      end
    end else begin
      if (x_r == X_ZERO) begin
        y_next_s = y_r + Y_ONE;
      end else begin
        x_next_s = x_r - X_ONE;
      end
    end
    last_cell_s = (y_r == Y_LAST) && (x_r == X_END);
`else
    if (x_r == X_LAST) begin
      x_next_s = X_ZERO;
      y_next_s = y_r + Y_ONE;
    end else begin
      x_next_s = x_r + X_ONE;
    end
    last_cell_s = (y_r == Y_LAST) && (x_r == X_LAST);
`endif
  end

  // Next-state and next-coordinate decode; RUN and pause only act between cells
  always_comb begin
    state_s = state_r;
    x_s     = x_r;
    y_s     = y_r;
    case (state_r)
      IDLE: begin
        if (RUN) begin
          state_s = ARM;
        end else begin
          state_s = IDLE;
        end
      end
      ARM: begin
        if (!RUN) begin
          state_s = IDLE;
        end else if (tick_rise_s) begin
          state_s = FETCH;
          x_s     = X_ZERO;
          y_s     = Y_ZERO;
        end else begin
          state_s = ARM;
        end
      end
      FETCH: begin
        if (paused_s) begin
          state_s = FETCH;
        end else begin
          state_s = COMMIT;
        end
      end
      COMMIT: begin
        if (last_cell_s) begin
          state_s = DONE;
          x_s     = X_ZERO;
          y_s     = Y_ZERO;
        end else if (!RUN) begin
          state_s = IDLE;
          x_s     = X_ZERO;
          y_s     = Y_ZERO;
        end else begin
          state_s = FETCH;
          x_s     = x_next_s;
          y_s     = y_next_s;
        end
      end
      DONE: begin
        x_s = X_ZERO;
        y_s = Y_ZERO;
        if (RUN) begin
          state_s = ARM;
        end else begin
          state_s = IDLE;
        end
      end
      default: begin
        state_s = IDLE;
        x_s     = X_ZERO;
        y_s     = Y_ZERO;
      end
    endcase
  end

  // State and coordinate registers
  always_ff @(posedge newLocClock or negedge RESET_SIM_N) begin
    if (!RESET_SIM_N) begin
      state_r <= IDLE;
      x_r     <= X_ZERO;
      y_r     <= Y_ZERO;
    end else begin
      state_r <= state_s;
      x_r     <= x_s;
      y_r     <= y_s;
    end
  end

  // Registered outputs decoded from the upcoming state, plus sticky overrun and sweep counter
  always_ff @(posedge newLocClock or negedge RESET_SIM_N) begin
    if (!RESET_SIM_N) begin
      write_flag_r <= 1'b0;
      hold_locs_r  <= 1'b1;
      busy_r       <= 1'b0;
      frame_done_r <= 1'b0;
      overrun_r    <= 1'b0;
      count_r      <= {CNT_bits{1'b0}};
    end else begin
      write_flag_r <= (state_s == COMMIT);
      busy_r       <= (state_s == FETCH) || (state_s == COMMIT);
      hold_locs_r  <= !((state_s == FETCH) || (state_s == COMMIT));
      frame_done_r <= (state_s == DONE);
      if (state_s == DONE) begin
        count_r <= count_r + CNT_ONE;
      end else begin
        count_r <= count_r;
      end
      if (tick_rise_s && ((state_r == FETCH) || (state_r == COMMIT) || (state_r == DONE))) begin
        overrun_r <= 1'b1;
      end else begin
        overrun_r <= overrun_r;
      end
    end
  end

  assign wr.writeLoc_x   = x_r;
  assign wr.writeLoc_y   = y_r;
  assign wr.write_flag   = write_flag_r;
  assign wr.hold_locs    = hold_locs_r;
  assign wr.sweep_busy   = busy_r;
  assign wr.frame_done   = frame_done_r;
  assign wr.tick_overrun = overrun_r;
  assign wr.sweep_count  = count_r;

endmodule

// File: doc/tick_sweep_sequencer.md
# tick_sweep_sequencer

Per-game-tick grid sweep sequencer that drives the environment write port. On each rising edge of the slowed game clock it walks every cell of the X_MAX+1 by Y_MAX+1 grid once. Each cell gets a fetch cycle, in which env_cache and the ant array settle on the presented coordinate, and then a commit cycle, in which `write_flag` is asserted so that `environment` latches the new sugar and signal values. It sits between `clock_cutter`/`simulation` control and the `location`, `env_cache`, `environment` and `ant` consumers of `writeLoc_x/y`, `write_flag` and `hold_locs`.

## Interface
Parameters:
- X_bits, 8, width of the column coordinate
- Y_bits, 7, width of the row coordinate
- X_MAX, 159, last column index
- Y_MAX, 119, last row index
- CNT_bits, 16, width of the completed-sweep counter

Ports:
- newLocClock  in  1  system clock (50 MHz); the only clock
- RESET_SIM_N  in  1  asynchronous, active-low reset
- RUN  in  1  simulation enabled (low during setup)
- game_tick  in  1  slowed game clock, same clock domain; the block edge-detects it internally
- KEY_PAUSE  in  1  raw active-low pushbutton; the block synchronizes it internally
- writeLoc_x  out  X_bits  current column
- writeLoc_y  out  Y_bits  current row
- write_flag  out  1  commit strobe for the current cell
- hold_locs  out  1  freeze request to the location generators
- sweep_busy  out  1  a sweep is in progress
- frame_done  out  1  one-cycle pulse when a sweep completes
- tick_overrun  out  1  sticky; a tick arrived while busy
- sweep_count  out  CNT_bits  number of completed sweeps; wraps

## Operation
- Reset values: writeLoc=(0,0), write_flag=0, hold_locs=1, sweep_busy=0, frame_done=0, tick_overrun=0, sweep_count=0, state IDLE. The pause synchronizer resets to 1 (not paused). The tick edge register resets to 0.
- Pause synchronization: KEY_PAUSE passes through a 2-flop synchronizer. `paused` = synchronized value == 0.
- Tick edge: `tick_rise` = game_tick & ~game_tick_q.
- IDLE: hold_locs=1. When RUN=1, go to ARM.
- ARM: hold_locs=1. On tick_rise, go to FETCH with coordinates (0,0).
- FETCH: hold_locs=0, write_flag=0.
  - If paused, stay in FETCH.
  - Else go to COMMIT.
- COMMIT: write_flag=1 for exactly one cycle. Then:
  - If the cell is the last in scan order, go to DONE.
  - Else if RUN=0, go to IDLE and reset coordinates to (0,0).
  - Else advance the coordinate and go to FETCH.
- DONE: frame_done=1, sweep_count+1, coordinates reset to (0,0), then go to ARM (or IDLE if RUN=0).
- sweep_busy=1 in FETCH and COMMIT only.
- Scan order (raster):
  - x increments.
  - At x==X_MAX: x wraps to 0 and y increments.
  - Last cell is (X_MAX, Y_MAX).
- Boundary conditions:
  - tick_rise while in FETCH, COMMIT or DONE: tick_overrun sets and stays set until reset. The tick is dropped, not queued.
  - A commit is never aborted. Pause and RUN are honoured only at cell boundaries.
  - RUN falling while in ARM: go to IDLE.
  - Reset asserted mid-sweep: all outputs return to their reset values immediately (asynchronous).

## Timing
- Cost per cell: 2 cycles when not paused.
- Cost per sweep: 2·(X_MAX+1)·(Y_MAX+1)+1 cycles = 38,401 at the default parameters.
- Tick-to-fetch latency: game_tick sampled high at edge n (after low at n−1) gives tick_rise during cycle n. FETCH of (0,0) is visible after edge n+1.
- Pause response: a KEY_PAUSE change is effective 2 edges later. Release resumes with COMMIT on the cycle after `paused` drops.
- All outputs are registered (Moore); no combinational input-to-output paths.

## Configuration
- SWEEP_SERPENTINE_EN defined:
  - Even rows scan x ascending; odd rows scan x descending.
  - Row change happens at x==X_MAX on even rows and at x==0 on odd rows.
  - Last cell is (0, Y_MAX) when Y_MAX is odd, otherwise (X_MAX, Y_MAX).
  - Consecutive cells are always adjacent, which keeps the env_cache neighbourhood warm.
- SWEEP_SERPENTINE_EN undefined: pure raster order as described under Operation.

## Test plan
- Reset, RUN=1, one game_tick rise → first write_flag at (0,0) 2 cycles after the rise. Exactly 19,200 write_flag pulses follow. frame_done pulses once, 38,401 cycles after the first FETCH. sweep_count=1.
- Small grid (X_MAX=3, Y_MAX=1), raster → commit sequence (0,0),(1,0),(2,0),(3,0),(0,1)…(3,1). With SWEEP_SERPENTINE_EN the sequence is (0,0)…(3,0),(3,1),(2,1),(1,1),(0,1).
- KEY_PAUSE held low for 10 cycles mid-sweep at cell (5,2) → write_flag stays 0 and coordinates stay (5,2). (5,2) commits exactly once after release.
- Second game_tick rise during a sweep → tick_overrun=1, no restart, sweep_count increments only once, tick_overrun stays 1 after completion.
- RUN dropped during FETCH of (7,0) → COMMIT of (7,0) occurs, then IDLE with coordinates (0,0) and hold_locs=1.
- Reset asserted during COMMIT → write_flag=0 and all outputs at reset values within the same cycle, without a clock edge.
